// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life engine.
package life_pkg;

    // Widest neighbour count is 8, so four bits are enough.
    localparam int NB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Flat cell index: row 0 occupies the lowest COLS bits.
    function automatic int idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/life_next_state.sv
// Combinational B3/S23 next-generation logic for a ROWS x COLS grid.
// With wrap high, neighbours are taken modulo the grid size. With wrap low,
// neighbours that fall outside the grid count as dead.
module life_next_state
    import life_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic [ROWS*COLS-1:0] grid,
    input  logic                 wrap,
    output logic [ROWS*COLS-1:0] next
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [8:0]      nb;
            logic [NB_W-1:0] cnt;

            // k walks the 3x3 window; k == 4 is the cell itself.
            for (genvar k = 0; k < 9; k++) begin : g_nb
                localparam int RR = r + k / 3 - 1;
                localparam int CC = c + k % 3 - 1;
                localparam bit INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                // The wrapped index equals the plain one for in-grid neighbours,
                // so one select serves both edge modes.
                localparam int RW = (RR + ROWS) % ROWS;
                localparam int CW = (CC + COLS) % COLS;
                if (k == 4) begin : g_self
                    assign nb[k] = 1'b0;
                end else begin : g_other
                    assign nb[k] = grid[idx(RW, CW, COLS)] & (INSIDE | wrap);
                end
            end

            // Population count of the eight neighbour bits.
            always_comb begin
                cnt = '0;
                for (int k = 0; k < 9; k++) begin
                    cnt = cnt + NB_W'(nb[k]);
                end
            end

            assign next[idx(r, c, COLS)] = (cnt == NB_W'(3)) |
                                           (grid[idx(r, c, COLS)] & (cnt == NB_W'(2)));
        end
    end

endmodule

// File: rtl/life_grid_engine.sv
// Game of Life engine: cell register, generation sequencing, halt detection.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting; a step pulse evaluates one generation
//   RUN   | free-running; one evaluation every TICK_DIV cycles
//   HALT  | last evaluation was a still life; only load or reset exits
module life_grid_engine
    import life_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int GEN_W    = 16,
    parameter int TICK_DIV = 25000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 load,
    input  logic                 step,
    input  logic                 run,
    input  logic                 wrap,
    output logic [ROWS*COLS-1:0] grid,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 gen_valid,
    output logic                 stable,
    output logic                 extinct,
    output logic                 running
);

    localparam int N      = ROWS * COLS;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e             state_q, state_d;
    logic [N-1:0]       grid_q, grid_d;
    logic [GEN_W-1:0]   gen_count_q, gen_count_d;
    logic               gen_valid_q, gen_valid_d;
    logic               stable_q, stable_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [N-1:0]       next_grid;
    logic               eval;

    life_next_state #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_next (
        .grid (grid_q),
        .wrap (wrap),
        .next (next_grid)
    );

    // Next-state logic: load beats everything, then run/step sequencing.
    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        gen_count_d = gen_count_q;
        gen_valid_d = 1'b0;
        stable_d    = stable_q;
        tick_d      = tick_q;
        eval        = 1'b0;

        if (load) begin
            grid_d      = seed;
            gen_count_d = '0;
            stable_d    = 1'b0;
            tick_d      = '0;
            state_d     = run ? RUN : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = RUN;
                        tick_d  = '0;
                    end else if (step) begin
                        eval = 1'b1;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_d = IDLE;
                        tick_d  = '0;
                    end else if (tick_q == TICK_W'(TICK_DIV - 1)) begin
                        tick_d = '0;
                        eval   = 1'b1;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                HALT: begin
                end
                default: state_d = IDLE;
            endcase

            if (eval) begin
                if (next_grid != grid_q) begin
                    grid_d      = next_grid;
                    gen_valid_d = 1'b1;
                    stable_d    = 1'b0;
                    if (gen_count_q != '1) begin
                        gen_count_d = gen_count_q + GEN_W'(1);
                    end
                end else begin
                    stable_d = 1'b1;
                    state_d  = HALT;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grid_q      <= '0;
            gen_count_q <= '0;
            gen_valid_q <= 1'b0;
            stable_q    <= 1'b0;
            tick_q      <= '0;
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            gen_count_q <= gen_count_d;
            gen_valid_q <= gen_valid_d;
            stable_q    <= stable_d;
            tick_q      <= tick_d;
        end
    end

    assign grid      = grid_q;
    assign gen_count = gen_count_q;
    assign gen_valid = gen_valid_q;
    assign stable    = stable_q;
    assign extinct   = (grid_q == '0);
    assign running   = (state_q == RUN);

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine with a cycle scoreboard and a
// reference Life model built on plain integer neighbour arithmetic.
module tb_life_grid_engine;

    localparam int R  = 8;
    localparam int C  = 8;
    localparam int N  = R * C;
    localparam int GW = 3;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  seed = '0;
    logic          load = 1'b0;
    logic          step = 1'b0;
    logic          run  = 1'b0;
    logic          wrap = 1'b0;
    logic [N-1:0]  grid;
    logic [GW-1:0] gen_count;
    logic          gen_valid;
    logic          stable;
    logic          extinct;
    logic          running;

    life_grid_engine #(
        .ROWS     (R),
        .COLS     (C),
        .GEN_W    (GW),
        .TICK_DIV (TD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seed      (seed),
        .load      (load),
        .step      (step),
        .run       (run),
        .wrap      (wrap),
        .grid      (grid),
        .gen_count (gen_count),
        .gen_valid (gen_valid),
        .stable    (stable),
        .extinct   (extinct),
        .running   (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  grid;
        logic [GW-1:0] gen;
        logic          gv;
        logic          stable;
        logic          running;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int gv_seen;

    // Reference model state: 0 idle, 1 run, 2 halt.
    logic [N-1:0]  m_grid;
    logic [GW-1:0] m_gen;
    logic          m_stable;
    int            m_state;
    int            m_tick;

    function automatic logic [N-1:0] life_ref(input logic [N-1:0] g, input logic w);
        logic [N-1:0] o;
        o = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int y;
                        int x;
                        y = r + dr;
                        x = c + dc;
                        if (w) begin
                            y = (y + R) % R;
                            x = (x + C) % C;
                        end
                        if (!(dr == 0 && dc == 0) && y >= 0 && y < R && x >= 0 && x < C)
                            n = n + int'(g[y * C + x]);
                    end
                end
                o[r * C + c] = (n == 3) || (g[r * C + c] && n == 2);
            end
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_grid   = '0;
        m_gen    = '0;
        m_stable = 1'b0;
        m_state  = 0;
        m_tick   = 0;
    endtask

    // Predict one clock edge from current inputs, push it, clock, pop, compare.
    task automatic cycle(input string tag);
        exp_t e;
        exp_t o;
        logic ev;
        logic [N-1:0] nx;
        e.gv = 1'b0;
        ev = 1'b0;
        if (load) begin
            m_grid   = seed;
            m_gen    = '0;
            m_stable = 1'b0;
            m_tick   = 0;
            m_state  = run ? 1 : 0;
        end else begin
            if (m_state == 0) begin
                if (run) begin
                    m_state = 1;
                    m_tick  = 0;
                end else if (step) ev = 1'b1;
            end else if (m_state == 1) begin
                if (!run) begin
                    m_state = 0;
                    m_tick  = 0;
                end else if (m_tick == TD - 1) begin
                    m_tick = 0;
                    ev = 1'b1;
                end else m_tick++;
            end
            if (ev) begin
                nx = life_ref(m_grid, wrap);
                if (nx != m_grid) begin
                    m_grid   = nx;
                    m_stable = 1'b0;
                    e.gv     = 1'b1;
                    if (m_gen != '1) m_gen = m_gen + 1'b1;
                end else begin
                    m_stable = 1'b1;
                    m_state  = 2;
                end
            end
        end
        e.grid    = m_grid;
        e.gen     = m_gen;
        e.stable  = m_stable;
        e.running = (m_state == 1);
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        chk({tag, " grid"},    grid,      o.grid);
        chk({tag, " gen"},     N'(gen_count), N'(o.gen));
        chk({tag, " gv"},      N'(gen_valid), N'(o.gv));
        chk({tag, " stable"},  N'(stable),    N'(o.stable));
        chk({tag, " running"}, N'(running),   N'(o.running));
        chk({tag, " extinct"}, N'(extinct),   N'(o.grid == '0));
        if (gen_valid) gv_seen++;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst grid",    grid, '0);
        chk("rst gen",     N'(gen_count), '0);
        chk("rst gv",      N'(gen_valid), '0);
        chk("rst stable",  N'(stable), '0);
        chk("rst extinct", N'(extinct), N'(1));
        chk("rst running", N'(running), '0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Test 1: horizontal blinker, dead borders
        wrap = 1'b0;
        seed = 64'h0000_0000_1C00_0000;
        load = 1'b1; cycle("t1 load"); load = 1'b0;
        step = 1'b1; cycle("t1 step1"); step = 1'b0;
        chk("t1 vert grid", grid, 64'h0000_0008_0808_0000);
        chk("t1 gen1", N'(gen_count), N'(1));
        chk("t1 gv pulse", N'(gen_valid), N'(1));
        cycle("t1 gap");
        chk("t1 gv drop", N'(gen_valid), '0);
        step = 1'b1; cycle("t1 step2"); step = 1'b0;
        chk("t1 horiz grid", grid, 64'h0000_0000_1C00_0000);
        chk("t1 gen2", N'(gen_count), N'(2));

        // Test 2: block still life halts
        seed = 64'h0303;
        load = 1'b1; cycle("t2 load"); load = 1'b0;
        step = 1'b1; cycle("t2 step"); step = 1'b0;
        chk("t2 stable", N'(stable), N'(1));
        chk("t2 gen0", N'(gen_count), '0);
        step = 1'b1; cycle("t2 halt step"); step = 1'b0;
        run = 1'b1;
        repeat (5) cycle("t2 halt run");
        run = 1'b0;
        chk("t2 halt grid", grid, 64'h0303);
        chk("t2 not running", N'(running), '0);

        // Test 3: vertical blinker at col 0, both edge modes
        seed = 64'h0000_0101_0100_0000;
        wrap = 1'b1;
        load = 1'b1; cycle("t3 load w"); load = 1'b0;
        step = 1'b1; cycle("t3 step w"); step = 1'b0;
        chk("t3 wrap grid", grid, 64'h0000_0083_0000_0000);
        wrap = 1'b0;
        load = 1'b1; cycle("t3 load d"); load = 1'b0;
        step = 1'b1; cycle("t3 step d"); step = 1'b0;
        chk("t3 dead grid", grid, 64'h0000_0003_0000_0000);
        step = 1'b1; cycle("t3 die"); step = 1'b0;
        chk("t3 extinct", N'(extinct), N'(1));
        step = 1'b1; cycle("t3 empty eval"); step = 1'b0;
        chk("t3 empty stable", N'(stable), N'(1));
        run = 1'b1; cycle("t3 halt run"); run = 1'b0;

        // Test 4: free-run with TICK_DIV=4
        seed = 64'h0000_0000_1C00_0000;
        load = 1'b1; cycle("t4 load"); load = 1'b0;
        run = 1'b1;
        cycle("t4 enter");
        gv_seen = 0;
        repeat (20) cycle("t4 run");
        chk("t4 pulses", N'(gv_seen), N'(5));
        chk("t4 gen5", N'(gen_count), N'(5));
        chk("t4 running", N'(running), N'(1));
        chk("t4 grid", grid, 64'h0000_0008_0808_0000);
        run = 1'b0;
        repeat (6) cycle("t4 idle");
        chk("t4 gen held", N'(gen_count), N'(5));

        // gen_count saturation: grid keeps advancing
        step = 1'b1;
        repeat (4) cycle("sat step");
        step = 1'b0;
        chk("sat gen", N'(gen_count), N'(7));
        chk("sat grid", grid, 64'h0000_0008_0808_0000);

        // Test 5: asynchronous reset mid-run
        load = 1'b1; run = 1'b1; cycle("t5 load"); load = 1'b0;
        repeat (2) cycle("t5 run");
        #2 reset_n = 1'b0;
        #1;
        chk("t5 grid", grid, '0);
        chk("t5 gen", N'(gen_count), '0);
        chk("t5 stable", N'(stable), '0);
        chk("t5 extinct", N'(extinct), N'(1));
        model_reset();
        run = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cycle("t5 after");
        chk("t5 idle", N'(running), '0);

        // Test 6: load wins over step in the same cycle
        seed = 64'h0000_0000_1C00_0000;
        load = 1'b1; step = 1'b1; cycle("t6 load+step");
        load = 1'b0; step = 1'b0;
        chk("t6 grid", grid, 64'h0000_0000_1C00_0000);
        chk("t6 gen", N'(gen_count), '0);
        chk("t6 gv", N'(gen_valid), '0);
        cycle("t6 gap");
        step = 1'b1; cycle("t6 step"); step = 1'b0;
        chk("t6 adv grid", grid, 64'h0000_0008_0808_0000);
        chk("t6 adv gen", N'(gen_count), N'(1));

        chk("scoreboard drained", N'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
